// File: rtl/jamma_scan.sv
`default_nettype none
// ============================================================================
// Module   : jamma_scan
// Purpose  : Single-clock JAMMA input scanner behind the IDE device-1 window.
//            Define JAMMA_TRACKBALL_EN to build the quadrature counters.
// Revision : 1.0 - initial release
// ============================================================================
module jamma_scan #(
  parameter int         N_INPUTS = 29,
  parameter int         DEB_W    = 4,
  parameter int         N_BALLS  = 4,
  parameter int         BALL_W   = 7,
  parameter logic [6:0] VERSION  = 7'h02
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [2:0]          da,
  input  logic                nCS0,
  input  logic                nCS1,
  input  logic                nDior,
  input  logic                nDiow,
  inout  wire  [7:0]          dd,
  inout  wire                 iordy,
  input  logic [N_INPUTS-1:0] P,
  input  logic [N_BALLS-1:0]  QA,
  input  logic [N_BALLS-1:0]  QB,
  output logic [1:0]          CoinCounter,
  output logic [1:0]          CoinLockout,
  output logic                LoFreq
);

  localparam int G = (N_INPUTS + 4) / 5;
`ifdef JAMMA_TRACKBALL_EN
  localparam int PKT = G + 1 + N_BALLS;
`else
  localparam int PKT = G + 1;
`endif
  localparam logic [3:0]       PKT_LAST = 4'(PKT - 1);
  localparam logic [2:0]       DA_DATA  = 3'd0;
  localparam logic [2:0]       DA_DEV   = 3'd6;
  localparam logic [2:0]       DA_CMD   = 3'd7;
  localparam logic [DEB_W-1:0] DEB_LAST = {DEB_W{1'b1}} - 1'b1;

  if (PKT > 16) begin : g_pkt_check
    $error("jamma_scan: packet exceeds 16 bytes");
  end
  if (BALL_W < 1 || BALL_W > 7) begin : g_ball_w_check
    $error("jamma_scan: BALL_W must be 1..7");
  end

  // ---------------- strobe synchronisers and edge detect --------------------
  logic [1:0] rd_sync_q, wr_sync_q;
  logic       rd_prev_q, wr_prev_q;
  logic       rd_fire, wr_fire;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_sync_q <= 2'b11;
      wr_sync_q <= 2'b11;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
    end else begin
      rd_sync_q <= {rd_sync_q[0], nDior};
      wr_sync_q <= {wr_sync_q[0], nDiow};
      rd_prev_q <= rd_sync_q[1];
      wr_prev_q <= wr_sync_q[1];
    end
  end

  assign rd_fire = rd_sync_q[1] & ~rd_prev_q;
  assign wr_fire = wr_sync_q[1] & ~wr_prev_q;

  // ---------------- address / write data latch ------------------------------
  logic       cs;
  logic       adr_cs_q;
  logic [2:0] adr_da_q;
  logic [7:0] wdat_q;

  assign cs = ~nCS0 & nCS1;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      adr_cs_q <= 1'b0;
      adr_da_q <= 3'd0;
      wdat_q   <= 8'h00;
    end else begin
      if (!rd_sync_q[1] || !wr_sync_q[1]) begin
        adr_cs_q <= cs;
        adr_da_q <= da;
      end
      if (!wr_sync_q[1]) begin
        wdat_q <= dd;
      end
    end
  end

  // ---------------- input debouncers ----------------------------------------
  logic [N_INPUTS-1:0] deb_w;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_deb
    logic [1:0]       sync_q;
    logic [DEB_W-1:0] cnt_q;
    logic             stable_q;

    // The increment that would reach all-ones is the update edge itself.
    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        sync_q   <= 2'b00;
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], P[i]};
        if (sync_q[1] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_LAST) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign deb_w[i] = stable_q;
  end

  // ---------------- quadrature counters -------------------------------------
`ifdef JAMMA_TRACKBALL_EN
  logic [N_BALLS-1:0][BALL_W-1:0] ball_w;

  for (genvar b = 0; b < N_BALLS; b++) begin : g_ball
    logic [1:0]        a_sync_q, b_sync_q, prev_q;
    logic [BALL_W-1:0] cnt_q;
    logic [1:0]        cur, pos_cur, pos_prev, step;

    assign cur = {a_sync_q[1], b_sync_q[1]};
    // Gray position: 00->0, 01->1, 11->2, 10->3; a step of 2 means both phases moved.
    assign pos_cur  = {cur[1], cur[1] ^ cur[0]};
    assign pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    assign step     = pos_cur - pos_prev;

    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        a_sync_q <= 2'b00;
        b_sync_q <= 2'b00;
        prev_q   <= 2'b00;
        cnt_q    <= '0;
      end else begin
        a_sync_q <= {a_sync_q[0], QA[b]};
        b_sync_q <= {b_sync_q[0], QB[b]};
        prev_q   <= cur;
        if (step == 2'd1) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (step == 2'd3) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end

    assign ball_w[b] = cnt_q;
  end
`else
  logic trackball_unused;
  assign trackball_unused = ^{QA, QB};
`endif

  // ---------------- control registers ---------------------------------------
  logic        bdev_q,   bdev_d;
  logic [3:0]  ptr_q,    ptr_d;
  logic [15:0] lfsr_q,   lfsr_d;
  logic [1:0]  coin_q,   coin_d;
  logic [1:0]  lock_q,   lock_d;
  logic        lofreq_q, lofreq_d;
  logic        snap_en;
  logic        lfsr_fb;

  assign lfsr_fb = (lfsr_q[1] ~^ lfsr_q[2]) ~^ (lfsr_q[15] ~^ lfsr_q[4]);

  always_comb begin
    bdev_d   = bdev_q;
    ptr_d    = ptr_q;
    lfsr_d   = lfsr_q;
    coin_d   = coin_q;
    lock_d   = lock_q;
    lofreq_d = lofreq_q;
    snap_en  = 1'b0;

    if (wr_fire && adr_cs_q) begin
      if (adr_da_q == DA_DEV) begin
        bdev_d = wdat_q[4];
      end else if (adr_da_q == DA_CMD && bdev_q) begin
        if (wdat_q[7:4] == 4'h5) begin
          {lock_d, coin_d} = wdat_q[3:0];
        end else if (wdat_q[7:4] == 4'h6) begin
          lofreq_d = wdat_q[0];
        end
      end
    end

    if (rd_fire && adr_cs_q && bdev_q) begin
      if (adr_da_q == DA_CMD) begin
        snap_en = 1'b1;
        ptr_d   = 4'd0;
      end else if (adr_da_q == DA_DATA) begin
        ptr_d  = (ptr_q == PKT_LAST) ? 4'd0 : ptr_q + 4'd1;
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
      end
    end
  end

  // ---------------- snapshot --------------------------------------------------
  logic [N_INPUTS-1:0] snap_in_q;
`ifdef JAMMA_TRACKBALL_EN
  logic [N_BALLS-1:0][BALL_W-1:0] snap_ball_q;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bdev_q      <= 1'b0;
      ptr_q       <= 4'd0;
      lfsr_q      <= 16'h0000;
      coin_q      <= 2'b00;
      lock_q      <= 2'b00;
      lofreq_q    <= 1'b0;
      snap_in_q   <= '0;
`ifdef JAMMA_TRACKBALL_EN
      snap_ball_q <= '0;
`endif
    end else begin
      bdev_q   <= bdev_d;
      ptr_q    <= ptr_d;
      lfsr_q   <= lfsr_d;
      coin_q   <= coin_d;
      lock_q   <= lock_d;
      lofreq_q <= lofreq_d;
      if (snap_en) begin
        snap_in_q   <= deb_w;
`ifdef JAMMA_TRACKBALL_EN
        snap_ball_q <= ball_w;
`endif
      end
    end
  end

  // ---------------- packet assembly -------------------------------------------
  logic [15:0][6:0] pkt_w;

  for (genvar k = 0; k < 16; k++) begin : g_byte
    if (k < G) begin : g_in
      for (genvar j = 0; j < 7; j++) begin : g_bit
        if (j < 5 && (5 * k + j) < N_INPUTS) begin : g_on
          assign pkt_w[k][j] = snap_in_q[5*k+j];
        end else begin : g_off
          assign pkt_w[k][j] = 1'b0;
        end
      end
    end else if (k == G) begin : g_ver
      assign pkt_w[k] = VERSION;
`ifdef JAMMA_TRACKBALL_EN
    end else if (k < PKT) begin : g_cnt
      assign pkt_w[k] = 7'(snap_ball_q[k-G-1]);
`endif
    end else begin : g_pad
      assign pkt_w[k] = 7'h00;
    end
  end

  // ---------------- bus drivers (combinational from the pins) -----------------
  logic       data_oe, cmd_oe;
  logic [7:0] dd_out;

  assign data_oe = ~nDior & cs & (da == DA_DATA) & bdev_q;
  assign cmd_oe  = ~nDior & cs & (da == DA_CMD) & bdev_q;
  assign dd_out  = data_oe ? {lfsr_q[15], pkt_w[ptr_q]} : {lfsr_q[15], 7'h00};
  assign dd      = (data_oe | cmd_oe) ? dd_out : 8'hzz;
  assign iordy   = (cs & bdev_q & (~nDior | ~nDiow)) ? 1'b1 : 1'bz;

  assign CoinCounter = coin_q;
  assign CoinLockout = lock_q;
  assign LoFreq      = lofreq_q;

endmodule
`default_nettype wire

// File: tb/tb_jamma_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_jamma_scan
// Purpose  : Self-checking bench for jamma_scan with a packet/LFSR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jamma_scan;

  localparam int         N_INPUTS = 29;
  localparam int         N_BALLS  = 4;
  localparam int         G        = 6;
  localparam logic [6:0] VERSION  = 7'h02;
`ifdef JAMMA_TRACKBALL_EN
  localparam int PKT = G + 1 + N_BALLS;
`else
  localparam int PKT = G + 1;
`endif

  logic                clk = 1'b0;
  logic                nReset = 1'b0;
  logic [2:0]          da = 3'd0;
  logic                nCS0 = 1'b1, nCS1 = 1'b1, nDior = 1'b1, nDiow = 1'b1;
  wire  [7:0]          dd;
  wire                 iordy;
  logic [7:0]          tb_dd = 8'h00;
  logic                tb_oe = 1'b0;
  logic [N_INPUTS-1:0] P = '0;
  logic [N_BALLS-1:0]  QA = '0, QB = '0;
  logic [1:0]          CoinCounter, CoinLockout;
  logic                LoFreq;

  assign dd = tb_oe ? tb_dd : 8'hzz;
  always #5 clk = ~clk;

  jamma_scan dut (
    .clk(clk), .nReset(nReset), .da(da), .nCS0(nCS0), .nCS1(nCS1),
    .nDior(nDior), .nDiow(nDiow), .dd(dd), .iordy(iordy), .P(P),
    .QA(QA), .QB(QB), .CoinCounter(CoinCounter), .CoinLockout(CoinLockout),
    .LoFreq(LoFreq)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic [N_INPUTS-1:0] m_stable = '0, m_snap = '0;
  int                  m_ball[N_BALLS], m_snap_ball[N_BALLS], qpos[N_BALLS];
  int                  m_ptr = 0;
  logic [15:0]         m_lfsr = 16'h0;
  logic [1:0]          m_coin = 2'b00, m_lock = 2'b00;
  logic                m_lofreq = 1'b0;
  logic [1:0]          gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], (l[1] ~^ l[2]) ~^ (l[15] ~^ l[4])};
  endfunction

  function automatic logic [6:0] exp_byte(input int k);
    if (k < G) return 7'((m_snap >> (5 * k)) & 29'h1f);
    if (k == G) return VERSION;
    return 7'(m_snap_ball[k-G-1] % 128);
  endfunction

  task automatic ide_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    nCS0 = 1'b0; nCS1 = 1'b1; da = a; tb_dd = d; tb_oe = 1'b1; nDiow = 1'b0;
    repeat (4) @(negedge clk);
    nDiow = 1'b1;
    repeat (5) @(negedge clk);
    tb_oe = 1'b0; nCS0 = 1'b1;
  endtask

  task automatic ide_read(input logic [2:0] a, output logic [7:0] d, output logic io);
    @(negedge clk);
    nCS0 = 1'b0; nCS1 = 1'b1; da = a; nDior = 1'b0;
    repeat (3) @(negedge clk);
    d = dd; io = iordy;
    @(negedge clk);
    nDior = 1'b1;
    repeat (5) @(negedge clk);
    nCS0 = 1'b1;
  endtask

  task automatic data_read(input string tag, output logic [7:0] got);
    logic io;
    ide_read(3'd0, got, io);
    chk(tag, got, {m_lfsr[15], exp_byte(m_ptr)});
    m_ptr  = (m_ptr + 1) % PKT;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic cmd_read();
    logic [7:0] got;
    logic       io;
    ide_read(3'd7, got, io);
    chk("cmd_read", got, {m_lfsr[15], 7'h00});
    m_snap      = m_stable;
    m_snap_ball = m_ball;
    m_ptr       = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_coin"}, CoinCounter, m_coin);
    chk({tag, "_lock"}, CoinLockout, m_lock);
    chk({tag, "_lofreq"}, LoFreq, m_lofreq);
  endtask

  task automatic cmd_write(input logic [7:0] c);
    ide_write(3'd7, c);
    if (c[7:4] == 4'h5) {m_lock, m_coin} = c[3:0];
    else if (c[7:4] == 4'h6) m_lofreq = c[0];
  endtask

  task automatic settle_inputs(input logic [N_INPUTS-1:0] v);
    P = v;
    repeat (20) @(negedge clk);
    m_stable = v;
  endtask

  task automatic glitch(input logic [N_INPUTS-1:0] v, input logic [N_INPUTS-1:0] mask);
    P = v ^ mask;
    repeat (10) @(negedge clk);
    P = v;
    repeat (20) @(negedge clk);
  endtask

  task automatic step_ball(input int b, input int dir);
    qpos[b]   = (qpos[b] + dir + 4) % 4;
    QA[b]     = gray[qpos[b]][1];
    QB[b]     = gray[qpos[b]][0];
    m_ball[b] = (m_ball[b] + dir + 128) % 128;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_packet(input string tag, input int n);
    logic [7:0] got;
    for (int i = 0; i < n; i++) data_read(tag, got);
  endtask

  initial begin
    logic [7:0]          got;
    logic                io;
    logic [N_INPUTS-1:0] v;
    int                  n;

    for (int b = 0; b < N_BALLS; b++) begin
      m_ball[b] = 0; m_snap_ball[b] = 0; qpos[b] = 0;
    end

    repeat (3) @(negedge clk);
    check_outs("reset");
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // Enable device 1; first read returns byte 0 of the all-zero snapshot.
    ide_write(3'd6, 8'h10);
    ide_read(3'd0, got, io);
    chk("first_data", got, {m_lfsr[15], exp_byte(m_ptr)});
    chk("first_data_zero", got[6:0], 7'h00);
    chk("iordy", io, 1'b1);
    m_ptr = 1; m_lfsr = lfsr_next(m_lfsr);
    read_packet("boot_pkt", PKT);

    cmd_write(8'h5A);
    chk("coin_lock_5A", CoinLockout, 2'b10);
    chk("coin_cnt_5A", CoinCounter, 2'b10);
    cmd_write(8'h61);
    chk("lofreq_61", LoFreq, 1'b1);
    cmd_write(8'h3F);
    check_outs("cmd_3F");

    v = N_INPUTS'($urandom);
    v[4:0] = 5'h15;
    settle_inputs(v);
    glitch(v, N_INPUTS'(1));
    cmd_read();
    data_read("byte0_15", got);
    chk("byte0_low", got[4:0], 5'h15);
    read_packet("inputs_pkt", PKT);

`ifdef JAMMA_TRACKBALL_EN
    for (int i = 0; i < 3; i++) step_ball(0, 1);
    cmd_read();
    read_packet("ball_fwd_pkt", G + 1);
    data_read("ball_fwd_pkt", got);
    chk("ball0_fwd", got[6:0], 7'h03);
    for (int i = 0; i < 5; i++) step_ball(0, -1);
    cmd_read();
    read_packet("ball_rev_pkt", G + 1);
    data_read("ball_rev_pkt", got);
    chk("ball0_rev", got[6:0], 7'h7E);
    cmd_read();
    read_packet("wrap_pkt", PKT - 1);
    data_read("wrap_last", got);
    chk("wrap_last_is_ball3", 32'(PKT - 1), 32'(G + N_BALLS));
    data_read("wrap_byte0", got);
`endif

    for (int r = 0; r < 6; r++) begin
      v = N_INPUTS'($urandom);
      settle_inputs(v);
      if ($urandom_range(0, 1) == 1) glitch(v, N_INPUTS'($urandom) | N_INPUTS'(1));
      cmd_write({4'h5, 4'($urandom)});
      check_outs("rand_coin");
      cmd_write({4'h6, 4'($urandom)});
      check_outs("rand_lofreq");
      got = 8'($urandom);
      if (got[7:4] == 4'h5 || got[7:4] == 4'h6) got[7:4] = 4'h3;
      cmd_write(got);
      check_outs("rand_other");
`ifdef JAMMA_TRACKBALL_EN
      for (int b = 0; b < N_BALLS; b++) begin
        n = $urandom_range(0, 12);
        for (int s = 0; s < n; s++) step_ball(b, (r % 2 == 0) ? 1 : -1);
      end
`endif
      cmd_read();
      read_packet("rand_pkt", $urandom_range(1, PKT + 3));
      if (r % 2 == 1) begin
        cmd_read();
        read_packet("rand_pkt2", 2);
      end
    end

    // Park the trackballs at gray 00 so release after reset counts nothing.
    for (int b = 0; b < N_BALLS; b++) while (qpos[b] != 0) step_ball(b, 1);
    @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    m_coin = 2'b00; m_lock = 2'b00; m_lofreq = 1'b0;
    check_outs("midreset");
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    m_ptr = 0; m_lfsr = 16'h0; m_snap = '0; m_stable = '0;
    for (int b = 0; b < N_BALLS; b++) begin
      m_ball[b] = 0; m_snap_ball[b] = 0;
    end
    repeat (20) @(negedge clk);
    m_stable = P;
    ide_write(3'd6, 8'h10);
    read_packet("post_reset_pkt", 3);
    cmd_read();
    read_packet("post_reset_snap", PKT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jamma_scan.md
# jamma_scan

Fully synchronous, parametrised JAMMA input scanner behind the IDE device-1 register window. It replaces strobe-clocked logic with a single `clk` domain: IDE strobes are synchronised and edge-detected, inputs are debounced, and a coherent snapshot of inputs and trackball counters is served as a byte packet through DataReg. Coin outputs and a noise stream on bit 7 are carried over from the previous generation.

## Interface
- `N_INPUTS`, 29: JAMMA input lines, packed 5 per packet byte.
- `DEB_W`, 4: debounce counter width; stable time is 2^DEB_W−1 clocks.
- `N_BALLS`, 4: quadrature channels.
- `BALL_W`, 7: trackball counter width (≤7).
- `VERSION`, 7'h02: version byte payload.
- `clk` in 1: system clock.
- `nReset` in 1: asynchronous, active-low reset.
- `da` in 3: IDE address.
- `nCS0`, `nCS1` in 1 each: IDE chip selects.
- `nDior`, `nDiow` in 1 each: IDE strobes, asynchronous to `clk`.
- `dd` inout 8: IDE data bus.
- `iordy` inout 1: driven 1 during device-1 access, otherwise Z.
- `P` in N_INPUTS: raw JAMMA inputs, active as wired.
- `QA`, `QB` in N_BALLS each: trackball phase inputs.
- `CoinCounter`, `CoinLockout` out 2 each: coin coil drives.
- `LoFreq` out 1: 15 kHz sync select.

## Operation
- Decode: cs = ~nCS0 & nCS1. DevReg is da=6 (any device). DataReg is da=0, CmdReg is da=7, both only when bDevice=1.
- Strobe path: each of nDior and nDiow goes through a 2-FF sync, then an edge register. An action fires on the synchronised rising edge.
- Address/data latch: {cs, da} loads every clk while the synchronised strobe is low. For writes, dd also loads. Actions use the latched values.
- Writes:
  - DevReg: bDevice ← dd[4].
  - CmdReg 0x5n: {CoinLockout, CoinCounter} ← n.
  - CmdReg 0x6x: LoFreq ← dd[0].
  - Other commands are ignored.
- CmdReg read completion:
  - snapshot ← {debounced inputs, ball counters}.
  - ptr ← 0.
  - LFSR unchanged.
- DataReg read completion:
  - ptr ← ptr+1, wrapping from PKT−1 to 0.
  - LFSR advances.
- Packet layout, with G = ceil(N_INPUTS/5) and PKT = G+1+N_BALLS. PKT ≤ 16 is an elaboration error otherwise.
  - Bytes 0..G−1: inputs 5k..5k+4 in bits [4:0]. Missing bits read 0.
  - Byte G: VERSION.
  - Bytes G+1..: ball counters, zero-extended to 7 bits.
- Read data: dd = {lfsr[15], byte[ptr][6:0]}. It is driven combinationally while ~nDior & cs & da==0 & bDevice, straight from the pins; otherwise Z. CmdReg reads return {lfsr[15], 7'h00}.
- LFSR: 16-bit shift left. Input bit = (l[1]~^l[2]) ~^ (l[15]~^l[4]).
- Debounce, per input:
  - 2-FF sync, then a counter. The counter clears whenever the synced value equals the stable value.
  - When the counter reaches all-ones, the stable value is updated and the counter clears.
- Quadrature, per channel:
  - 2-FF sync of A/B, previous-state register.
  - Gray step 00→01→11→10→00 gives +1; the reverse gives −1. Counters wrap modulo 2^BALL_W.
  - Both phases changing together is ignored, with no count.

## Timing
- Reset values:
  - ptr, snapshot, LFSR, bDevice, Coin*, LoFreq, and all counters = 0.
  - Debounced stable values = 0.
  - dd and iordy = Z.
- A write or read action takes effect on the 3rd clk edge after the strobe pin rises (2 sync + 1 edge). Register outputs update at that same edge.
- Host requirement: strobe low ≥ 3 clk and strobe high ≥ 4 clk.
- Debounce latency from a clean input change to the stable update is 2 + 2^DEB_W−1 clocks. With defaults: 17.
- Quadrature latency is 3 clk from a pin edge to the counter update.
- Snapshot coinciding with a counter or debounce update captures the pre-update value.
- Ptr wrap: the read after byte PKT−1 returns byte 0.
- Reset asserted mid-cycle clears everything immediately. A strobe still low at release produces no action until its next rising edge.

## Configuration
- `JAMMA_TRACKBALL_EN` defined: quadrature counters are built and the packet includes N_BALLS counter bytes.
- Undefined:
  - QA/QB are unconnected.
  - No counter logic is built.
  - PKT = G+1, and ptr wraps after the version byte.

## Test plan
- Reset, then write DevReg 0x10, then read DataReg → dd[6:0] = 0x00 and ptr = 1. iordy is 1 during the access.
- Hold P[4:0] = 5'h15 for 20 clk, read CmdReg, then read DataReg → byte0[4:0] = 0x15. Glitches of 10 clk on P[0] do not change the stable value.
- Defaults with `JAMMA_TRACKBALL_EN`: 11 DataReg reads after CmdReg → byte 6 = 0x02, and the 12th read returns byte 0 (wrap).
- Apply 3 forward steps on QA0/QB0, then CmdReg read → byte 7 = 0x03. 5 reverse steps, then snapshot → byte 7 = 0x7E.
- Write CmdReg 0x5A → CoinLockout = 2'b10, CoinCounter = 2'b10. Write 0x61 → LoFreq = 1. Write 0x3F → no change.
- From reset, bit 7 over 20 DataReg reads matches the LFSR model seeded with 0. CmdReg reads leave the sequence unchanged.
